// File: rtl/series_sum_engine.sv
// Series accumulator: after a released start pulse, adds term(i) for i = 1..N
// (i, i*i or 2i-1) one per clock, with busy/done status and a sticky overflow flag.
module series_sum_engine #(
    parameter int N_W   = 8,
    parameter int SUM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   n_in,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             overflow
);

    localparam int TERM_W = 2 * N_W + 1;
    localparam int WIDE_W = (TERM_W > SUM_W) ? TERM_W : SUM_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        CALC     = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_W:0]       cnt_q, cnt_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [1:0]         mode_q, mode_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;

    logic [TERM_W-1:0]  idx;
    logic [TERM_W-1:0]  term;
    logic [WIDE_W-1:0]  term_wide;
    logic [SUM_W:0]     add_res;
    logic               term_big;
    logic               last_step;
    logic               calc_step;
    logic               launch;

    // Term evaluated at full 2*N_W+1 precision before fitting it to SUM_W.
    assign idx = TERM_W'(cnt_q);

    always_comb begin
        unique case (mode_q)
            2'b01:   term = idx * idx;
            2'b10:   term = (idx << 1) - TERM_W'(1);
            default: term = idx;
        endcase
    end

    assign term_wide = WIDE_W'(term);
    assign term_big  = |(term_wide >> SUM_W);
    assign add_res   = {1'b0, sum_q} + {1'b0, term_wide[SUM_W-1:0]};
    assign last_step = (cnt_q == {1'b0, n_q});
    assign launch    = (state_q == IDLE) && start;
    assign calc_step = (state_q == CALC) && !abort && (n_q != '0);

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values; reset is synchronous and active-low.
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            mode_q  <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = WAIT_REL;
            WAIT_REL: begin
                if (abort)       state_d = IDLE;
                else if (!start) state_d = CALC;
            end
            CALC: begin
                if (abort)                        state_d = IDLE;
                else if ((n_q == '0) || last_step) state_d = DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on launch, one add per productive CALC cycle.
    always_comb begin
        cnt_d  = cnt_q;
        n_d    = n_q;
        mode_d = mode_q;
        sum_d  = sum_q;
        ovf_d  = ovf_q;
        if (launch) begin
            n_d    = n_in;
            mode_d = mode;
            cnt_d  = (N_W+1)'(1);
            sum_d  = '0;
            ovf_d  = 1'b0;
        end else if (calc_step) begin
            sum_d = add_res[SUM_W-1:0];
            cnt_d = cnt_q + (N_W+1)'(1);
            ovf_d = ovf_q | add_res[SUM_W] | term_big;
        end
    end

    // Status outputs decoded from the state alone.
    always_comb begin
        busy = (state_q == WAIT_REL) || (state_q == CALC);
        done = (state_q == DONE);
    end

    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule
